// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the EX/MEM stages, the register file write port and decode hazard lookup.
// The slave modport is the arbiter side; the master modport is the pipeline/bench side.
interface regfile_write_arbiter_if #(
  parameter int QUEUE_DEPTH = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [ADDR_WIDTH-1:0] ex_addr;
  logic [DATA_WIDTH-1:0] ex_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [ADDR_WIDTH-1:0] rs_query;
  logic [ADDR_WIDTH-1:0] rt_query;
  logic                  rs_busy;
  logic                  rt_busy;
  logic [CNT_W-1:0]      queue_count;

  modport master (
    output ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data, rs_query, rt_query,
    input  ex_ready, mem_ready, wb_we, wb_addr, wb_data, rs_busy, rt_busy, queue_count
  );

  modport slave (
    input  ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data, rs_query, rt_query,
    output ex_ready, mem_ready, wb_we, wb_addr, wb_data, rs_busy, rt_busy, queue_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between buffered EX results and unbuffered MEM returns,
// with a pending-write scoreboard for decode. REGFILE_ARB_ZERO_FILTER_EN drops writes to register 0.
module regfile_write_arbiter #(
  parameter int QUEUE_DEPTH  = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5
) (
  input logic                   clock_i,
  input logic                   reset_i,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

`ifdef REGFILE_ARB_ZERO_FILTER_EN
  localparam bit ZERO_FILTER = 1'b1;
`else
  localparam bit ZERO_FILTER = 1'b0;
`endif

  logic [ADDR_WIDTH-1:0] fifo_addr_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  wb_we_q, wb_we_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

  logic empty, full, force_fifo;
  logic enq, mem_issue, fifo_issue;
  logic rs_hit, rt_hit;
  logic [PTR_W-1:0] offset;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(QUEUE_DEPTH));
  assign force_fifo = (starve_q == STV_W'(STARVE_LIMIT)) && !empty;

  assign bus.ex_ready    = !reset_i && !full;
  assign bus.mem_ready   = !reset_i && !force_fifo;
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.queue_count = count_q;

  // Filtered register-0 requests still handshake but leave the write slot free for the FIFO.
  assign enq        = bus.ex_valid && bus.ex_ready && !(ZERO_FILTER && bus.ex_addr == '0);
  assign mem_issue  = bus.mem_valid && bus.mem_ready && !(ZERO_FILTER && bus.mem_addr == '0);
  assign fifo_issue = !reset_i && !empty && !mem_issue;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wb_we_d   = mem_issue || fifo_issue;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    starve_d  = '0;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fifo_issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (enq && !fifo_issue) count_d = count_q + CNT_W'(1);
    else if (!enq && fifo_issue) count_d = count_q - CNT_W'(1);
    if (mem_issue) begin
      wb_addr_d = bus.mem_addr;
      wb_data_d = bus.mem_data;
      if (!empty && starve_q != STV_W'(STARVE_LIMIT)) starve_d = starve_q + STV_W'(1);
      else if (!empty) starve_d = starve_q;
    end else if (fifo_issue) begin
      wb_addr_d = fifo_addr_q[rd_ptr_q];
      wb_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q] <= bus.ex_addr;
      fifo_data_q[wr_ptr_q] <= bus.ex_data;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    offset = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q) begin
        if (fifo_addr_q[i] == bus.rs_query) rs_hit = 1'b1;
        if (fifo_addr_q[i] == bus.rt_query) rt_hit = 1'b1;
      end
    end
  end

  assign bus.rs_busy = !(ZERO_FILTER && bus.rs_query == '0) &&
                       (rs_hit || (wb_we_q && wb_addr_q == bus.rs_query) ||
                        (bus.mem_valid && bus.mem_addr == bus.rs_query));
  assign bus.rt_busy = !(ZERO_FILTER && bus.rt_query == '0) &&
                       (rt_hit || (wb_we_q && wb_addr_q == bus.rt_query) ||
                        (bus.mem_valid && bus.mem_addr == bus.rt_query));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_write_arbiter;
  localparam int QD = 4;
  localparam int SL = 3;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_ARB_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.QUEUE_DEPTH(QD), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.QUEUE_DEPTH(QD), .STARVE_LIMIT(SL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW))
    dut (.clock_i(clk), .reset_i(rst), .bus(bus));

  wr_t           mq[$];
  int            starve;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            n_pass, n_fail, n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_busy(input logic [AW-1:0] a);
    if (ZF && a == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == a) return 1'b1;
    if (e_we && e_addr == a) return 1'b1;
    if (bus.mem_valid && bus.mem_addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    starve = 0;
    e_we = 1'b0;
    e_addr = '0;
    e_data = '0;
  endtask

  task automatic check_cycle();
    chk("ex_ready", 64'(bus.ex_ready), 64'(mq.size() != QD));
    chk("mem_ready", 64'(bus.mem_ready), 64'(!(starve == SL && mq.size() > 0)));
    chk("queue_count", 64'(bus.queue_count), 64'(mq.size()));
    chk("wb_we", 64'(bus.wb_we), 64'(e_we));
    chk("wb_addr", 64'(bus.wb_addr), 64'(e_addr));
    chk("wb_data", 64'(bus.wb_data), 64'(e_data));
    chk("rs_busy", 64'(bus.rs_busy), 64'(model_busy(bus.rs_query)));
    chk("rt_busy", 64'(bus.rt_busy), 64'(model_busy(bus.rt_query)));
  endtask

  // Next-edge effect of the current inputs: one write slot, MEM preferred unless the FIFO has waited SL grants.
  task automatic model_advance();
    int  sz;
    bit  forced, mem_grant, popped;
    wr_t h;
    sz = mq.size();
    forced = (starve == SL) && (sz > 0);
    mem_grant = bus.mem_valid && !forced;
    popped = 1'b0;
    if (mem_grant && !(ZF && bus.mem_addr == 0)) begin
      e_we = 1'b1;
      e_addr = bus.mem_addr;
      e_data = bus.mem_data;
    end else if (sz > 0) begin
      h = mq.pop_front();
      popped = 1'b1;
      e_we = 1'b1;
      e_addr = h.a;
      e_data = h.d;
    end else begin
      e_we = 1'b0;
    end
    if (popped || !(mem_grant && sz > 0)) starve = 0;
    else if (starve < SL) starve++;
    if (bus.ex_valid && sz < QD && !(ZF && bus.ex_addr == 0))
      mq.push_back('{a: bus.ex_addr, d: bus.ex_data});
  endtask

  task automatic tick();
    #2;
    check_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    model_reset();
    bus.ex_valid = 0; bus.ex_addr = '0; bus.ex_data = '0;
    bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.rs_query = '0; bus.rt_query = '0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_wb_we", 64'(bus.wb_we), 64'd0);
    chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_ex_ready", 64'(bus.ex_ready), 64'd0);
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
    rst = 1'b0;
    tick();

    // Single EX write, busy window on rs
    bus.rs_query = 5'd5; bus.rt_query = 5'd7;
    bus.ex_valid = 1; bus.ex_addr = 5'd5; bus.ex_data = 32'hDEADBEEF;
    tick();
    idle();
    #1 chk("t2_busy_e1", 64'(bus.rs_busy), 64'd1);
    tick();
    #1 chk("t2_we", 64'(bus.wb_we), 64'd1);
    chk("t2_addr", 64'(bus.wb_addr), 64'd5);
    chk("t2_data", 64'(bus.wb_data), 64'hDEADBEEF);
    chk("t2_busy_e2", 64'(bus.rs_busy), 64'd1);
    tick();
    #1 chk("t2_busy_e3", 64'(bus.rs_busy), 64'd0);
    tick();

    // EX and MEM together: MEM first
    bus.ex_valid = 1; bus.ex_addr = 5'd3; bus.ex_data = 32'h11;
    bus.mem_valid = 1; bus.mem_addr = 5'd4; bus.mem_data = 32'h22;
    tick();
    idle();
    #1 chk("t3_first", 64'(bus.wb_addr), 64'd4);
    tick();
    #1 chk("t3_second", 64'(bus.wb_addr), 64'd3);
    chk("t3_second_we", 64'(bus.wb_we), 64'd1);
    tick(); tick();

    // Starvation: MEM held, one EX queued
    bus.ex_valid = 1; bus.ex_addr = 5'd9; bus.ex_data = 32'h99;
    bus.mem_valid = 1; bus.mem_addr = 5'd10; bus.mem_data = 32'h100;
    tick();
    bus.ex_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      bus.mem_data = 32'h100 + i;
      #1 chk("t4_grant", 64'(bus.mem_ready), 64'd1);
      tick();
    end
    bus.mem_data = 32'h104;
    #1 chk("t4_forced", 64'(bus.mem_ready), 64'd0);
    tick();
    #1 chk("t4_ex_issued", 64'(bus.wb_addr), 64'd9);
    chk("t4_resume", 64'(bus.mem_ready), 64'd1);
    tick();
    idle();
    tick(); tick();

    // FIFO full under MEM pressure
    bus.mem_valid = 1; bus.mem_addr = 5'd20;
    bus.ex_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.ex_addr = 5'(11 + i); bus.ex_data = 32'h500 + i; bus.mem_data = 32'h600 + i;
      tick();
    end
    bus.ex_addr = 5'd15; bus.ex_data = 32'h504;
    #1 chk("t5_count_full", 64'(bus.queue_count), 64'd4);
    chk("t5_ex_stall", 64'(bus.ex_ready), 64'd0);
    tick();
    #1 chk("t5_ex_free", 64'(bus.ex_ready), 64'd1);
    tick();
    idle();
    for (int i = 0; i < 8; i++) tick();
    chk("t5_drained", 64'(bus.queue_count), 64'd0);

    // Register 0 write
    bus.ex_valid = 1; bus.ex_addr = 5'd0; bus.ex_data = 32'hABC;
    #1 chk("t6_ready", 64'(bus.ex_ready), 64'd1);
    tick();
    idle();
`ifdef REGFILE_ARB_ZERO_FILTER_EN
    #1 chk("t6_count", 64'(bus.queue_count), 64'd0);
    tick();
    #1 chk("t6_we", 64'(bus.wb_we), 64'd0);
`else
    #1 chk("t6_count", 64'(bus.queue_count), 64'd1);
    tick();
    #1 chk("t6_we", 64'(bus.wb_we), 64'd1);
    chk("t6_addr", 64'(bus.wb_addr), 64'd0);
`endif
    tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.ex_valid  = ($urandom_range(0, 99) < 55);
      bus.ex_addr   = 5'($urandom_range(0, 7));
      bus.ex_data   = $urandom;
      bus.mem_valid = ($urandom_range(0, 99) < 50);
      bus.mem_addr  = 5'($urandom_range(0, 7));
      bus.mem_data  = $urandom;
      bus.rs_query  = 5'($urandom_range(0, 7));
      bus.rt_query  = 5'($urandom_range(0, 7));
      tick();
    end

    // Reset mid-traffic with three queued entries
    idle();
    for (int i = 0; i < 6; i++) tick();
    bus.mem_valid = 1; bus.mem_addr = 5'd21; bus.ex_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_addr = 5'(25 + i); bus.ex_data = 32'h700 + i; bus.mem_data = 32'h800 + i;
      tick();
    end
    #1 chk("t1_count3", 64'(bus.queue_count), 64'd3);
    #1 rst = 1'b1;
    model_reset();
    #1 chk("t1_we", 64'(bus.wb_we), 64'd0);
    chk("t1_count", 64'(bus.queue_count), 64'd0);
    chk("t1_ex_ready", 64'(bus.ex_ready), 64'd0);
    chk("t1_mem_ready", 64'(bus.mem_ready), 64'd0);
    idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("t1_ex_ready_rel", 64'(bus.ex_ready), 64'd1);
    for (int i = 0; i < 3; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
